// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types, constants and round-robin search for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_e;

    localparam int CNT_W   = 8;
    localparam int MAX_REQ = 32;

    // First set bit of req strictly after last_id, wrapping modulo num_req; returns last_id if req is empty.
    function automatic logic [4:0] rr_next(input logic [MAX_REQ-1:0] req,
                                           input logic [4:0]         last_id,
                                           input logic [5:0]         num_req);
        logic [5:0] idx;
        logic       found;
        rr_next = last_id;
        found   = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = {1'b0, last_id} + 6'(k);
            if (6'(k) <= num_req && !found) begin
                if (idx >= num_req) begin
                    idx = idx - num_req;
                end
                if (req[idx[4:0]]) begin
                    rr_next = idx[4:0];
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin picker over the producer request vector
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_id_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    id_o
);

    logic [MAX_REQ-1:0] req_ext;
    logic [4:0]         pick;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req_i;
        pick                   = rr_next(req_ext, 5'(last_id_i), 6'(NUM_REQ));
    end

    assign valid_o = |req_i;
    assign id_o    = ID_W'(pick);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among producers
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            accept_o,
    output logic [NUM_REQ-1:0]            wr_done_o,
    output logic [CNT_W-1:0]              drop_cnt_o,
    output logic [CNT_W-1:0]              ovf_cnt_o,
    output logic                          fifo_wr_en_o,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in_o,
    input  logic                          fifo_full_i,
    input  logic                          fifo_wr_ack_i,
    input  logic                          fifo_overflow_i
);

    localparam int                 ID_W       = $clog2(NUM_REQ);
    localparam int                 BURST_W    = $clog2(MAX_BURST + 1);
    localparam logic [ID_W-1:0]    LAST_RST   = ID_W'(NUM_REQ - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     cur_id_q, cur_id_d;
    logic [ID_W-1:0]     last_id_q, last_id_d;
    logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic                pend_v_q;
    logic [ID_W-1:0]     pend_id_q;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]    ovf_cnt_q, ovf_cnt_d;
    logic                pick_valid;
    logic [ID_W-1:0]     pick_id;
    logic                granted;
    logic                wr_en;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i     (req_i),
        .last_id_i (last_id_q),
        .valid_o   (pick_valid),
        .id_o      (pick_id)
    );

    // Full is checked combinationally so a write is never presented to a full FIFO.
    assign granted      = (state_q == GRANT);
    assign wr_en        = granted && req_i[cur_id_q] && !fifo_full_i;
    assign fifo_wr_en_o = wr_en;
    assign gnt_o        = granted ? (NUM_REQ'(1) << cur_id_q) : '0;
    assign accept_o     = gnt_o & {NUM_REQ{wr_en}};
    assign wr_done_o    = (pend_v_q && fifo_wr_ack_i) ? (NUM_REQ'(1) << pend_id_q) : '0;
    assign drop_cnt_o   = drop_cnt_q;
    assign ovf_cnt_o    = ovf_cnt_q;

    always_comb begin
        fifo_data_in_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (granted && cur_id_q == ID_W'(i)) begin
                fifo_data_in_o = req_data_i[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_id_d    = cur_id_q;
        last_id_d   = last_id_q;
        burst_cnt_d = burst_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid && !fifo_full_i) begin
                    state_d     = GRANT;
                    cur_id_d    = pick_id;
                    last_id_d   = pick_id;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!req_i[cur_id_q]) begin
                    state_d = IDLE;
                end else if (wr_en) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    if (burst_cnt_q == BURST_LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pend_v_q && !fifo_wr_ack_i && drop_cnt_q != CNT_MAX) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
        if (fifo_overflow_i && ovf_cnt_q != CNT_MAX) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cur_id_q    <= '0;
            last_id_q   <= LAST_RST;
            burst_cnt_q <= '0;
            pend_v_q    <= 1'b0;
            pend_id_q   <= '0;
            drop_cnt_q  <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_id_q    <= cur_id_d;
            last_id_q   <= last_id_d;
            burst_cnt_q <= burst_cnt_d;
            pend_v_q    <= wr_en;
            pend_id_q   <= cur_id_q;
            drop_cnt_q  <= drop_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench with FIFO/producer environment and reference model
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int MB    = 4;
    localparam int DEPTH = 8;

    typedef logic [W-1:0] word_t;
    typedef struct packed {
        logic [1:0] id;
        word_t      data;
    } wr_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   gnt, accept, wr_done;
    logic [7:0]     drop_cnt, ovf_cnt;
    logic           fifo_wr_en;
    word_t          fifo_data_in;
    logic           fifo_full = 1'b0, fifo_wr_ack = 1'b0, fifo_overflow = 1'b0;

    fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .req_data_i(req_data),
        .gnt_o(gnt), .accept_o(accept), .wr_done_o(wr_done),
        .drop_cnt_o(drop_cnt), .ovf_cnt_o(ovf_cnt),
        .fifo_wr_en_o(fifo_wr_en), .fifo_data_in_o(fifo_data_in),
        .fifo_full_i(fifo_full), .fifo_wr_ack_i(fifo_wr_ack), .fifo_overflow_i(fifo_overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Environment state
    word_t          prod_q[N][$];
    word_t          fifo_mem[$];
    word_t          exp_rd_q[$];
    wr_t            exp_wr_q[$];
    logic [N-1:0]   req_nxt = '0;
    logic [N*W-1:0] data_nxt = '0;
    logic           full_nxt = 1'b0, ack_nxt = 1'b0, ovf_nxt = 1'b0;
    int             rd_mode = 1;
    int             rd_once = 0;
    bit             force_nack = 0, rand_mode = 0, inj_ovf = 0;
    int             n_writes = 0;
    int             n_done[N];
    int             acc_cnt[N];
    int             grant_log[$];
    logic [N-1:0]   gnt_prev = '0;

    // Reference model state
    bit m_busy = 0;
    int m_cur = 0, m_last = N - 1, m_cnt = 0;
    bit m_pend_v = 0;
    int m_pend_id = 0, m_drop = 0, m_ovf = 0;

    function automatic int oh_id(input logic [N-1:0] v);
        oh_id = -1;
        for (int i = 0; i < N; i++) if (v[i]) oh_id = i;
    endfunction

    initial begin
        for (int i = 0; i < N; i++) begin
            n_done[i]  = 0;
            acc_cnt[i] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            req           = req_nxt;
            req_data      = data_nxt;
            fifo_full     = full_nxt;
            fifo_wr_ack   = ack_nxt;
            fifo_overflow = ovf_nxt;
        end
    end

    always @(negedge clk) begin : env
        logic [N-1:0] e_gnt, e_done;
        logic         e_wen, push, rd;
        word_t        e_data, got;
        wr_t          e;
        int           pick;

        // Reference: what the arbiter must present this cycle
        e_gnt  = m_busy ? (N'(1) << m_cur) : '0;
        e_wen  = m_busy && req[m_cur] && !fifo_full;
        e_data = m_busy ? req_data[m_cur*W +: W] : '0;
        e_done = (m_pend_v && fifo_wr_ack) ? (N'(1) << m_pend_id) : '0;
        chk("gnt", gnt, e_gnt);
        chk("wr_en", fifo_wr_en, e_wen);
        chk("accept", accept, e_gnt & {N{e_wen}});
        chk("data_in", fifo_data_in, e_data);
        chk("wr_done", wr_done, e_done);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("ovf_cnt", ovf_cnt, m_ovf);
        if (e_wen) begin
            exp_wr_q.push_back('{id: 2'(m_cur), data: req_data[m_cur*W +: W]});
            exp_rd_q.push_back(req_data[m_cur*W +: W]);
        end

        // Monitor: every issued write must match a predicted one
        if (fifo_wr_en) begin
            n_writes++;
            chk("wr_predicted", exp_wr_q.size() != 0, 1);
            if (exp_wr_q.size() != 0) begin
                e = exp_wr_q.pop_front();
                chk("wr_id", oh_id(accept), e.id);
                chk("wr_data", fifo_data_in, e.data);
            end
        end
        if (exp_wr_q.size() != 0) begin
            chk("wr_issued", fifo_wr_en, 1);
            exp_wr_q.delete();
        end
        for (int i = 0; i < N; i++) begin
            if (accept[i]) acc_cnt[i]++;
            if (wr_done[i]) n_done[i]++;
        end
        if (gnt != 0 && gnt != gnt_prev) grant_log.push_back(oh_id(gnt));
        gnt_prev = gnt;

        // FIFO write side behaviour and readback
        push = fifo_wr_en && !fifo_full;
        rd = fifo_mem.size() > 0 &&
             (rd_mode == 1 || (rd_mode == 2 && $urandom_range(0, 9) < 4) || rd_once > 0);
        if (rd) begin
            if (rd_once > 0) rd_once--;
            got = fifo_mem.pop_front();
            chk("readback_avail", exp_rd_q.size() != 0, 1);
            if (exp_rd_q.size() != 0) chk("readback", got, exp_rd_q.pop_front());
        end
        if (push) fifo_mem.push_back(fifo_data_in);
        full_nxt = fifo_mem.size() >= DEPTH;
        ack_nxt  = push && !force_nack && !(rand_mode && $urandom_range(0, 99) < 10);
        ovf_nxt  = (fifo_wr_en && fifo_full) || inj_ovf || (rand_mode && $urandom_range(0, 99) < 3);

        // Producers: pop on accept, optional random refill, hold req while data remains
        for (int i = 0; i < N; i++) begin
            if (accept[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
            if (rand_mode && prod_q[i].size() < 3 && $urandom_range(0, 3) == 0)
                prod_q[i].push_back(W'($urandom));
            req_nxt[i]          = prod_q[i].size() > 0;
            data_nxt[i*W +: W]  = req_nxt[i] ? prod_q[i][0] : '0;
        end

        // Reference model advance
        if (rst) begin
            m_busy = 0; m_cur = 0; m_last = N - 1; m_cnt = 0;
            m_pend_v = 0; m_pend_id = 0; m_drop = 0; m_ovf = 0;
        end else begin
            if (m_pend_v && !fifo_wr_ack && m_drop < 255) m_drop++;
            if (fifo_overflow && m_ovf < 255) m_ovf++;
            m_pend_v  = e_wen;
            m_pend_id = m_cur;
            if (!m_busy) begin
                if (req != 0 && !fifo_full) begin
                    pick = -1;
                    for (int k = 1; k <= N; k++)
                        if (pick < 0 && req[(m_last + k) % N]) pick = (m_last + k) % N;
                    m_busy = 1; m_cur = pick; m_last = pick; m_cnt = 0;
                end
            end else if (!req[m_cur]) begin
                m_busy = 0;
            end else if (e_wen) begin
                m_cnt++;
                if (m_cnt == MB) m_busy = 0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drain(input string name, input int limit);
        int  n;
        bit  busy;
        n = 0;
        busy = 1;
        while (busy && n < limit) begin
            cyc(1);
            n++;
            busy = gnt != 0 || fifo_mem.size() > 0;
            for (int i = 0; i < N; i++) if (prod_q[i].size() > 0) busy = 1;
        end
        chk({name, "_drain_timeout"}, busy, 0);
        cyc(3);
    endtask

    task automatic chk_log(input string name, input int k, input int exp);
        if (grant_log.size() > k) chk(name, grant_log[k], exp);
        else chk({name, "_len"}, grant_log.size(), k + 1);
    endtask

    initial begin : main
        int base_w, base_d, base_a;
        bit hit;

        // Reset with every producer requesting
        for (int i = 0; i < N; i++) repeat (2) prod_q[i].push_back(W'($urandom));
        cyc(3);
        chk("rst_req_seen", req, 4'b1111);
        chk("rst_gnt", gnt, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_accept", accept, 0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_data_in", fifo_data_in, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_ovf", ovf_cnt, 0);
        cyc(1);
        rst = 1'b0;
        grant_log.delete();
        cyc(1);
        chk("first_gnt", gnt, 4'b0001);
        drain("reset", 200);
        chk_log("first_owner", 0, 0);

        // Single producer, three words
        grant_log.delete();
        base_w = n_writes; base_d = n_done[2];
        prod_q[2].push_back(16'h00A1);
        prod_q[2].push_back(16'h00A2);
        prod_q[2].push_back(16'h00A3);
        drain("single", 100);
        chk("single_writes", n_writes - base_w, 3);
        chk("single_done", n_done[2] - base_d, 3);
        chk("single_grants", grant_log.size(), 1);
        chk_log("single_owner", 0, 2);

        // Fairness from reset: everyone streams 8 words
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        grant_log.delete();
        base_w = n_writes;
        for (int i = 0; i < N; i++) repeat (8) prod_q[i].push_back(W'($urandom));
        drain("fair", 300);
        chk("fair_writes", n_writes - base_w, 32);
        chk("fair_grants", grant_log.size(), 8);
        chk_log("fair_0", 0, 0);
        chk_log("fair_1", 1, 1);
        chk_log("fair_2", 2, 2);
        chk_log("fair_3", 3, 3);
        chk_log("fair_4", 4, 0);

        // Full: no reads, producer 0 streams 10 words
        rd_mode = 0;
        base_w = n_writes;
        repeat (10) prod_q[0].push_back(W'($urandom));
        cyc(40);
        chk("full_writes", n_writes - base_w, 8);
        chk("full_left", prod_q[0].size(), 2);
        chk("full_ovf", ovf_cnt, 0);
        chk("full_drop", drop_cnt, 0);
        rd_once = 1;
        cyc(10);
        chk("full_one_more", n_writes - base_w, 9);
        chk("full_stall_gnt", gnt, 4'b0001);
        chk("full_stall_wr_en", fifo_wr_en, 0);
        rd_mode = 1;
        drain("full", 200);

        // Externally reported overflow is only counted
        inj_ovf = 1;
        cyc(3);
        inj_ovf = 0;
        cyc(3);
        chk("ovf_count", ovf_cnt, 3);

        // No acks for 300 writes: drop counter saturates, no wr_done
        force_nack = 1;
        base_d = n_done[1];
        repeat (300) prod_q[1].push_back(W'($urandom));
        drain("drop", 1000);
        force_nack = 0;
        chk("drop_sat", drop_cnt, 255);
        chk("drop_no_done", n_done[1] - base_d, 0);

        // Reset during producer 2's second write
        base_a = acc_cnt[2]; base_d = n_done[2];
        repeat (4) prod_q[2].push_back(W'($urandom));
        prod_q[0].push_back(W'($urandom));
        hit = 0;
        for (int t = 0; t < 50 && !hit; t++) begin
            cyc(1);
            if (acc_cnt[2] == base_a + 1 && accept[2]) begin
                rst = 1'b1;
                hit = 1;
            end
        end
        chk("midburst_reached", hit, 1);
        cyc(1);
        rst = 1'b0;
        grant_log.delete();
        chk("midburst_gnt", gnt, 0);
        chk("midburst_wr_done", wr_done, 0);
        chk("midburst_drop", drop_cnt, 0);
        chk("midburst_req", req, 4'b0101);
        cyc(1);
        chk("midburst_regrant", gnt, 4'b0001);
        drain("midburst", 100);
        chk_log("midburst_owner", 0, 0);
        chk("midburst_done", n_done[2] - base_d, 3);

        // Randomized traffic, reads, nacks and overflow reports
        rand_mode = 1;
        rd_mode = 2;
        cyc(3000);
        rand_mode = 0;
        rd_mode = 1;
        drain("random", 2000);
        chk("random_readback_left", exp_rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
